// File: rtl/signed_mul_host.sv
// Host-side initiator for a bit-serial signed multiplier: shifts two operands out
// MSB first, triggers the multiply, then shifts the 2W-bit product back in.
module signed_mul_host #(
   parameter int W       = 12,
   parameter int OUT_LAT = 1,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     x_par,
   input  logic [W-1:0]     y_par,
   output logic             busy,
   output logic [2*W-1:0]   result,
   output logic             result_valid,
   output logic             error,
   output logic             x_in,
   output logic             y_in,
   output logic             sx,
   output logic             sy,
   input  logic             fx,
   input  logic             fy,
   output logic             mul,
   input  logic             done,
   output logic             sz,
   input  logic             z_out,
   input  logic             fz
);

   localparam int PW      = 2 * W;
   localparam int ULEN    = PW + OUT_LAT;
   localparam int CW      = $clog2(ULEN + 1);
   localparam int TW      = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WAIT_F, S_MUL, S_WAIT_DONE, S_UNLOAD, S_WAIT_FZ, S_RESULT
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   bitCnt_q, bitCnt_d;
   logic [TW-1:0]   toCnt_q, toCnt_d;
   logic [W-1:0]    xSh_q, xSh_d;
   logic [W-1:0]    ySh_q, ySh_d;
   logic [PW-1:0]   prod_q, prod_d;
   logic [PW-1:0]   result_q, result_d;
   logic            error_q, error_d;
   logic            toHit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         bitCnt_q <= '0;
         toCnt_q  <= '0;
         xSh_q    <= '0;
         ySh_q    <= '0;
         prod_q   <= '0;
         result_q <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitCnt_q <= bitCnt_d;
         toCnt_q  <= toCnt_d;
         xSh_q    <= xSh_d;
         ySh_q    <= ySh_d;
         prod_q   <= prod_d;
         result_q <= result_d;
         error_q  <= error_d;
      end
   end

   // One shared timeout counter; it is zeroed on the transition into every wait state.
   assign toHit = (toCnt_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d  = state_q;
      bitCnt_d = bitCnt_q;
      toCnt_d  = toCnt_q;
      xSh_d    = xSh_q;
      ySh_d    = ySh_q;
      prod_d   = prod_q;
      result_d = result_q;
      error_d  = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               xSh_d    = x_par;
               ySh_d    = y_par;
               error_d  = 1'b0;
               bitCnt_d = '0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            xSh_d = {xSh_q[W-2:0], 1'b0};
            ySh_d = {ySh_q[W-2:0], 1'b0};
            if (bitCnt_q == CW'(W - 1)) begin
               bitCnt_d = '0;
               toCnt_d  = '0;
               state_d  = S_WAIT_F;
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         S_WAIT_F: begin
            if (fx && fy) begin
               state_d = S_MUL;
            end else if (toHit) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               toCnt_d = toCnt_q + 1'b1;
            end
         end
         S_MUL: begin
            toCnt_d = '0;
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (done) begin
               bitCnt_d = '0;
               state_d  = S_UNLOAD;
            end else if (toHit) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               toCnt_d = toCnt_q + 1'b1;
            end
         end
         S_UNLOAD: begin
            // The first OUT_LAT strobe cycles only prime the multiplier's output.
            if (bitCnt_q >= CW'(OUT_LAT)) begin
               prod_d = {prod_q[PW-2:0], z_out};
            end
            if (bitCnt_q == CW'(ULEN - 1)) begin
               toCnt_d = '0;
               state_d = S_WAIT_FZ;
            end else begin
               bitCnt_d = bitCnt_q + 1'b1;
            end
         end
         S_WAIT_FZ: begin
            if (fz) begin
               result_d = prod_q;
               state_d  = S_RESULT;
            end else if (toHit) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               toCnt_d = toCnt_q + 1'b1;
            end
         end
         S_RESULT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy         = (state_q != S_IDLE);
   assign sx           = (state_q == S_LOAD);
   assign sy           = (state_q == S_LOAD);
   assign x_in         = sx & xSh_q[W-1];
   assign y_in         = sy & ySh_q[W-1];
   assign mul          = (state_q == S_MUL);
   assign sz           = (state_q == S_UNLOAD);
   assign result_valid = (state_q == S_RESULT);
   assign result       = result_q;
   assign error        = error_q;

endmodule
